branch_execution_unit: RTL
==========================

BRANCH_EXECUTION_UNIT -- requirements
Module: branch_execution_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter TAG_WIDTH, default 5, ROB tag width.
REQ-003 SHALL have parameter BUF_DEPTH, default 2, result buffer entries (power of two, >=2).
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports: clk in 1 (rising edge), reset in 1 (synchronous, active-high).
REQ-005 SHALL have ports ready_to_execute in 1 (RS operands ready), accept out 1 (instruction taken this cycle).
REQ-006 SHALL have inputs v1 XLEN (rs1), v2 XLEN (rs2), pc XLEN, imm XLEN, predicted_next_instruction XLEN.
REQ-007 SHALL have inputs jump 1 (JAL), jalr 1, branch 1, funct3 3, branch_prediction 1, rob_tag_in TAG_WIDTH.
REQ-008 SHALL have flush in 1 (kill all held results), cdb_grant in 1 (head result consumed).
REQ-009 SHALL have outputs write_to_buffer 1 (head valid), next_instruction XLEN, link_value XLEN (pc+4), branch_mispredicted 1, rob_tag_out TAG_WIDTH.

Function
REQ-010 SHALL compute taken per funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; 010/011 not taken.
REQ-011 SHALL resolve target: jump -> pc+imm; jalr -> (v1+imm) with bit 0 cleared; branch -> taken ? pc+imm : pc+4; none set -> pc+4.
REQ-012 SHALL use modulo 2^XLEN arithmetic for all adds; no overflow flag.
REQ-013 SHALL set branch_mispredicted = (resolved next_instruction != predicted_next_instruction); branch_prediction is carried only for tracing, not used in the compare.
REQ-014 SHALL assert accept = ready_to_execute && !full && !flush, combinationally.
REQ-015 SHALL enqueue {next_instruction, link_value, mispredicted, rob_tag_in} at the rising edge of each accept cycle.
REQ-016 SHALL present the result with write_to_buffer=1 no earlier than the cycle after accept (latency 1 when empty).
REQ-017 SHALL dequeue the head at the edge where write_to_buffer && cdb_grant; cdb_grant with empty buffer ignored.
REQ-018 SHALL hold head outputs stable while write_to_buffer=1 and cdb_grant=0.
REQ-019 SHALL support simultaneous enqueue and dequeue in one cycle, count unchanged, order preserved (FIFO).
REQ-020 SHALL treat full as count==BUF_DEPTH; a grant in the full cycle does not raise accept that cycle.
REQ-021 SHALL wrap read/write pointers modulo BUF_DEPTH.
REQ-022 SHALL on flush empty the buffer at the next edge, discarding any simultaneous enqueue or dequeue; write_to_buffer=0 the following cycle.

Reset
REQ-023 SHALL on reset clear count and pointers; write_to_buffer=0, accept=0 during reset cycle.
REQ-024 SHALL drive next_instruction, link_value, rob_tag_out, branch_mispredicted to 0 when buffer empty or in reset.
REQ-025 SHALL have reset take priority over flush, accept and grant; entries in flight are lost.

Structure
REQ-026 SHALL take funct3 encodings (BEQ..BGEU) from shared package branch_pkg.
REQ-027 SHALL place the combinational compare/target logic in sub-module branch_resolver; buffer and control in the top.

Verification
REQ-028 SHALL cover: BEQ v1=v2=5, pc=0x100, imm=0x20, predicted 0x104 -> next 0x120, mispredicted=1, valid one cycle after accept.
REQ-029 SHALL cover: BLT v1=0xFFFFFFFF, v2=1 taken; BLTU same operands not taken -> next pc+4.
REQ-030 SHALL cover: JALR v1=0x1003, imm=0 -> next 0x1002, link_value pc+4.
REQ-031 SHALL cover: cdb_grant=0, three ready cycles, BUF_DEPTH=2 -> accept 1,1,0; grant drains tags in order.
REQ-032 SHALL cover: buffer holding 2 results, flush with ready_to_execute=1 -> accept=0, write_to_buffer=0 next cycle.
REQ-033 SHALL cover: reset asserted with buffer full -> write_to_buffer=0 and all result outputs 0 the next cycle.

Source files
------------

// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared branch funct3 encodings
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

endpackage

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - combinational branch condition, target and mispredict compare
module branch_resolver
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] v1,
  input  logic [XLEN-1:0] v2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] predicted_next_instruction,
  input  logic            jump,
  input  logic            jalr,
  input  logic            branch,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] next_instruction,
  output logic [XLEN-1:0] link_value,
  output logic            mispredicted
);

  logic            taken;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_target;

  assign pc_plus_imm = pc + imm;
  assign link_value  = pc + XLEN'(4);
  // JALR target always has bit 0 cleared
  assign jalr_target = (v1 + imm) & ~XLEN'(1);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      BEQ:     taken = (v1 == v2);
      BNE:     taken = (v1 != v2);
      BLT:     taken = ($signed(v1) < $signed(v2));
      BGE:     taken = ($signed(v1) >= $signed(v2));
      BLTU:    taken = (v1 < v2);
      BGEU:    taken = (v1 >= v2);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_instruction = link_value;
    if (jump)
      next_instruction = pc_plus_imm;
    else if (jalr)
      next_instruction = jalr_target;
    else if (branch && taken)
      next_instruction = pc_plus_imm;
  end

  assign mispredicted = (next_instruction != predicted_next_instruction);

endmodule

// File: rtl/branch_execution_unit.sv
// rtl/branch_execution_unit.sv - branch execute stage with in-order result buffer toward the CDB
module branch_execution_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 5,
  parameter int BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ready_to_execute,
  output logic                 accept,
  input  logic [XLEN-1:0]      v1,
  input  logic [XLEN-1:0]      v2,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      imm,
  input  logic [XLEN-1:0]      predicted_next_instruction,
  input  logic                 jump,
  input  logic                 jalr,
  input  logic                 branch,
  input  logic [2:0]           funct3,
  input  logic                 branch_prediction,
  input  logic [TAG_WIDTH-1:0] rob_tag_in,
  input  logic                 flush,
  input  logic                 cdb_grant,
  output logic                 write_to_buffer,
  output logic [XLEN-1:0]      next_instruction,
  output logic [XLEN-1:0]      link_value,
  output logic                 branch_mispredicted,
  output logic [TAG_WIDTH-1:0] rob_tag_out
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  logic [XLEN-1:0]      res_next;
  logic [XLEN-1:0]      res_link;
  logic                 res_mis;

  logic [XLEN-1:0]      next_mem [BUF_DEPTH];
  logic [XLEN-1:0]      link_mem [BUF_DEPTH];
  logic                 mis_mem  [BUF_DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem  [BUF_DEPTH];

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 dequeue;

  // Prediction bit travels with the op for tracing only
  logic                 unused_prediction;
  assign unused_prediction = branch_prediction;

  branch_resolver #(
    .XLEN(XLEN)
  ) u_resolver (
    .v1                         (v1),
    .v2                         (v2),
    .pc                         (pc),
    .imm                        (imm),
    .predicted_next_instruction (predicted_next_instruction),
    .jump                       (jump),
    .jalr                       (jalr),
    .branch                     (branch),
    .funct3                     (funct3),
    .next_instruction           (res_next),
    .link_value                 (res_link),
    .mispredicted               (res_mis)
  );

  assign full            = (count == FULL_CNT);
  assign accept          = ready_to_execute && !full && !flush && !reset;
  assign write_to_buffer = (count != '0) && !reset;
  assign dequeue         = write_to_buffer && cdb_grant;

  // Storage needs no reset: entries are only visible while counted
  always_ff @(posedge clk) begin
    if (accept) begin
      next_mem[wr_ptr] <= res_next;
      link_mem[wr_ptr] <= res_link;
      mis_mem[wr_ptr]  <= res_mis;
      tag_mem[wr_ptr]  <= rob_tag_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept)
        wr_ptr <= (wr_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (dequeue)
        rd_ptr <= (rd_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(accept) - CNT_W'(dequeue);
    end
  end

  assign next_instruction    = write_to_buffer ? next_mem[rd_ptr] : '0;
  assign link_value          = write_to_buffer ? link_mem[rd_ptr] : '0;
  assign branch_mispredicted = write_to_buffer ? mis_mem[rd_ptr]  : 1'b0;
  assign rob_tag_out         = write_to_buffer ? tag_mem[rd_ptr]  : '0;

endmodule
